// File: rtl/mult_dse_pkg.sv
// Shared types and width helpers for the multiplier design-space harness.
package mult_dse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 16;

  // Bits needed to encode a requester index (at least one bit).
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Bits needed to hold a settle count of 0 .. cycles-1 (at least one bit).
  function automatic int cnt_width(input int cycles);
    if (cycles <= 2) begin
      return 1;
    end else begin
      return $clog2(cycles);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid
);

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    int idx;
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(rr_ptr) + off) % NREQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IDW'(idx);
      end else begin
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external combinational multiplier between NREQ requesters,
// returns tagged products and counts mismatches against an exact golden product.
module mult_share_arbiter
  import mult_dse_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int IDW           = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_p,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic                  rsp_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(SETTLE_CYCLES);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDW-1:0]     rr_ptr_r;
  logic [IDW-1:0]     id_r;
  logic [PW-1:0]      golden_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [NREQ-1:0]    grant_s;
  logic [IDW-1:0]     grant_id_s;
  logic               grant_valid_s;
  logic               hs_s;
  logic               settle_done_s;
  logic               rsp_fire_s;
  logic               mismatch_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic [WIDTH-1:0]   b_sel_s;
  logic [PW-1:0]      prod_s;
  logic [IDW-1:0]     ptr_nxt_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_r),
    .grant       (grant_s),
    .grant_id    (grant_id_s),
    .grant_valid (grant_valid_s)
  );

  // Operand selection, golden product and control strobes.
  always_comb begin
    a_sel_s       = req_a[int'(grant_id_s)*WIDTH +: WIDTH];
    b_sel_s       = req_b[int'(grant_id_s)*WIDTH +: WIDTH];
    prod_s        = PW'(a_sel_s) * PW'(b_sel_s);
    hs_s          = rst_n && (state_r == IDLE) && grant_valid_s;
    settle_done_s = (state_r == EVAL) && (cnt_r == '0);
    rsp_fire_s    = (state_r == RESP) && rsp_valid && rsp_ready;
    mismatch_s    = (mul_p != golden_r);
    if (rsp_id == IDW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = rsp_id + IDW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_nxt_s = EVAL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EVAL: begin
        if (settle_done_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = EVAL;
        end
      end
      RESP: begin
        if (rsp_fire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: ready only for the current grant while idle and out of reset.
  always_comb begin
    if (rst_n && (state_r == IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    busy = (state_r != IDLE);
  end

  // Operand, golden, id and settle-counter registers loaded on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      golden_r <= '0;
      id_r     <= '0;
      cnt_r    <= '0;
    end else if (hs_s) begin
      mul_a    <= a_sel_s;
      mul_b    <= b_sel_s;
      golden_r <= prod_s;
      id_r     <= grant_id_s;
      cnt_r    <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((state_r == EVAL) && (cnt_r != '0)) begin
      cnt_r    <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Response channel: capture on settle, hold until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      rsp_err   <= 1'b0;
    end else if (settle_done_s) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id_r;
      rsp_p     <= mul_p;
      rsp_err   <= mismatch_s;
    end else if (rsp_fire_s) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

  // Round-robin pointer advances past the requester just answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (rsp_fire_s) begin
      rr_ptr_r <= ptr_nxt_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Saturating mismatch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (settle_done_s && mismatch_s && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end else begin
      err_cnt <= err_cnt;
    end
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one combinational `multiplier` instance (ports A, B, P) among NREQ requesters.
- Arbitrates round-robin over valid/ready request channels and holds the operands stable while the multiplier settles.
- Captures P into a registered response channel, tagged with the requester id.
- Checks each product against a golden A*B and counts mismatches. This gives the DSE flow a cycle-accurate harness for candidate exact and approximate multipliers.

Parameters:
- WIDTH, 8, operand width; the product is 2*WIDTH.
- NREQ, 4, number of requesters (≥2).
- SETTLE_CYCLES, 1, cycles operands are held before P is sampled (≥1).
- IDW, $clog2(NREQ), requester id width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*WIDTH  packed operand A; slice i belongs to requester i
- req_b  in  NREQ*WIDTH  packed operand B
- mul_a  out  WIDTH  to multiplier A (registered)
- mul_b  out  WIDTH  to multiplier B (registered)
- mul_p  in  2*WIDTH  from multiplier P
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  id of the requester being answered
- rsp_p  out  2*WIDTH  captured product
- rsp_err  out  1  rsp_p != golden product for this transaction
- err_cnt  out  16  saturating count of mismatches
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, mul_a=mul_b=0.
  - rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, err_cnt=0.
  - req_ready=0 while rst_n is low.
- FSM states: IDLE → EVAL → RESP → IDLE.
- IDLE:
  - grant = first asserted req_valid searching from rr_ptr upward, wrapping at NREQ.
  - req_ready[grant]=1 combinationally; all other ready bits are 0. No valid → no ready, stay in IDLE.
  - On handshake: latch mul_a/mul_b from the grant slices, latch golden = a*b (full 2*WIDTH), latch id, load settle counter = SETTLE_CYCLES-1, go to EVAL.
- EVAL:
  - mul_a/mul_b are held constant; req_ready=0.
  - Counter decrements each cycle.
  - At counter==0: rsp_p←mul_p, rsp_err←(mul_p!=golden), rsp_valid←1, and err_cnt increments on mismatch (saturates at 16'hFFFF). Go to RESP.
- RESP:
  - rsp_valid, rsp_p, rsp_id and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid←0, rr_ptr←(id+1) mod NREQ, go to IDLE.
  - No new grant in that same cycle, so back-to-back issue spacing is SETTLE_CYCLES+2 cycles minimum.
- Latency: handshake in cycle T gives rsp_valid high from cycle T+1+SETTLE_CYCLES.
- Requester rule: once req_valid is asserted, hold the operands stable until req_ready. Dropping valid before grant is allowed; the arbiter re-evaluates every IDLE cycle.
- Wrap-around: rr_ptr=NREQ-1 with grant at NREQ-1 gives next rr_ptr=0.
- Width: golden uses unsigned WIDTH×WIDTH→2*WIDTH with no truncation; 255*255=65025.
- Reset mid-transaction drops it silently. A requester still holding valid is re-granted after release, starting from rr_ptr=0.

Decomposition:
- Shared package mult_dse_pkg:
  - state enum {IDLE, EVAL, RESP}
  - ERR_CNT_W=16
  - width helper functions for IDW
- Sub-module rr_arbiter: parameterised NREQ; inputs req vector and rr_ptr; outputs one-hot grant and encoded grant id; purely combinational.
- The FSM, the registers and the multiplier connection stay in mult_share_arbiter. The multiplier is instantiated by the bench or top level, not inside this block.

Test Plan:
- Single request: req0 a=3, b=2, rsp_ready=1 → req_ready[0] in cycle 0; rsp_valid in cycle 2 with rsp_p=6, rsp_id=0, rsp_err=0.
- All four requesters valid simultaneously, a=i+1, b=10 → grants in order 0,1,2,3; rsp_p=10,20,30,40; each grant spaced 3 cycles apart.
- Fairness: req0 and req2 permanently valid → grant sequence 0,2,0,2,…; req1 and req3 never readied.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_p/rsp_id stable, req_ready stays 0, busy=1; release → IDLE next cycle.
- Fault injection: bench multiplier returns (A*B)^1 for a=255, b=255 → rsp_p=65024, rsp_err=1, err_cnt=1. A correct model for a=255, b=255 gives 65025 with rsp_err=0.
- Reset during EVAL: assert rst_n low → all outputs zero immediately; after release, the still-valid req1 is granted and answered correctly.
